sr_bank_arbiter: RTL and testbench

SR_BANK_ARBITER -- requirements
Module: sr_bank_arbiter

---
 rtl/sr_bank_pkg.sv | 35 +++
 rtl/sr_bank_cell.sv | 38 +++
 rtl/sr_bank_arbiter.sv | 112 +++++++++++
 tb/tb_sr_bank_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sr_bank_pkg.sv
// +-----------------------------------------------------------------------+
// | Module  : sr_bank_pkg                                                 |
// | Brief   : Shared encodings for the SR cell bank arbiter.              |
// |           Optional macro SR_TOGGLE_EN makes cmd 11 a JK-style toggle. |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
`default_nettype none

package sr_bank_pkg;

  localparam int NCELL_DEFAULT = 8;

  // Bit 1 of a command drives s, bit 0 drives r.
  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_RESET = 2'b01;
  localparam logic [1:0] CMD_SET   = 2'b10;
  localparam logic [1:0] CMD_BOTH  = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_APPLY = 2'b01;
  localparam logic [1:0] ST_GAP   = 2'b10;

`ifdef SR_TOGGLE_EN
  localparam logic TOGGLE_EN = 1'b1;
`else
  localparam logic TOGGLE_EN = 1'b0;
`endif

  function automatic logic cmd_is_illegal(input logic [1:0] cmd);
    return (cmd == CMD_BOTH) && !TOGGLE_EN;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sr_bank_cell.sv
// +-----------------------------------------------------------------------+
// | Module  : sr_cell                                                     |
// | Brief   : One clocked SR flip-flop; s=r=1 holds, or toggles when      |
// |           SR_TOGGLE_EN is defined.                                    |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
`default_nettype none

module sr_cell (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= 1'b0;
    end else begin
      case ({s, r})
        2'b10:   r_q <= 1'b1;
        2'b01:   r_q <= 1'b0;
`ifdef SR_TOGGLE_EN
        2'b11:   r_q <= ~r_q;
`endif
        default: r_q <= r_q;
      endcase
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/sr_bank_arbiter.sv
// +-----------------------------------------------------------------------+
// | Module  : sr_bank_arbiter                                             |
// | Brief   : Round-robin two-port arbiter applying SR commands to a bank |
// |           of sr_cell instances; one command per three cycles.         |
// |           Optional macro SR_TOGGLE_EN makes cmd 11 a toggle.          |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
`default_nettype none

module sr_bank_arbiter
  import sr_bank_pkg::*;
#(
  parameter int NCELL = NCELL_DEFAULT,
  parameter int IDXW  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_a,
  input  logic [1:0]      cmd_a,
  input  logic [IDXW-1:0] idx_a,
  input  logic            req_b,
  input  logic [1:0]      cmd_b,
  input  logic [IDXW-1:0] idx_b,
  output logic            gnt_a,
  output logic            gnt_b,
  output logic [NCELL-1:0] q,
  output logic            busy,
  output logic            err
);

  localparam logic [31:0] C_NCELL = NCELL;

  logic [1:0]      r_state;
  logic [1:0]      r_cmd;
  logic [IDXW-1:0] r_idx;
  logic            r_last_b;
  logic            r_gnt_a;
  logic            r_gnt_b;
  logic            r_err;

  logic            w_win_b;
  logic            w_idx_ok;
  logic            w_apply;
  logic [NCELL-1:0] w_s;
  logic [NCELL-1:0] w_r;

  // B wins only if A is absent or A was the previous winner.
  assign w_win_b  = req_b & (~req_a | ~r_last_b);
  assign w_idx_ok = ({{(32-IDXW){1'b0}}, r_idx} < C_NCELL);
  assign w_apply  = (r_state == ST_APPLY) & w_idx_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cmd    <= CMD_NOP;
      r_idx    <= '0;
      r_last_b <= 1'b1;
      r_gnt_a  <= 1'b0;
      r_gnt_b  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_gnt_a <= 1'b0;
      r_gnt_b <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_a | req_b) begin
            r_state  <= ST_APPLY;
            r_cmd    <= w_win_b ? cmd_b : cmd_a;
            r_idx    <= w_win_b ? idx_b : idx_a;
            r_last_b <= w_win_b;
            r_gnt_a  <= ~w_win_b;
            r_gnt_b  <= w_win_b;
          end
        end
        ST_APPLY: begin
          r_state <= ST_GAP;
          if (!w_idx_ok || cmd_is_illegal(r_cmd)) begin
            r_err <= 1'b1;
          end
        end
        ST_GAP:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  generate
    for (genvar i = 0; i < NCELL; i++) begin : g_cell
      logic w_hit;
      assign w_hit  = w_apply & (r_idx == IDXW'(i));
      assign w_s[i] = w_hit & r_cmd[1];
      assign w_r[i] = w_hit & r_cmd[0];

      sr_cell u_cell (
        .clk (clk),
        .rst (rst),
        .s   (w_s[i]),
        .r   (w_r[i]),
        .q   (q[i])
      );
    end
  endgenerate

  // A reset during APPLY withdraws the grant that cycle as well.
  assign gnt_a = r_gnt_a & ~rst;
  assign gnt_b = r_gnt_b & ~rst;
  assign busy  = (r_state != ST_IDLE);
  assign err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_sr_bank_arbiter.sv
// +-----------------------------------------------------------------------+
// | Module  : tb_sr_bank_arbiter                                          |
// | Brief   : Self-checking bench for sr_bank_arbiter (NCELL=8 and 6).    |
// |           Honors SR_TOGGLE_EN for cmd 11 expectations.                |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_sr_bank_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, req_b;
  logic [1:0] cmd_a, cmd_b;
  logic [2:0] idx_a, idx_b;
  logic       gnt_a, gnt_b, busy, err;
  logic [7:0] q;

  logic       req6, gnt6_a, gnt6_b, busy6, err6;
  logic [1:0] cmd6;
  logic [2:0] idx6;
  logic       req6_b = 1'b0;
  logic [1:0] cmd6_b = 2'b00;
  logic [2:0] idx6_b = 3'd0;
  logic [5:0] q6;

  sr_bank_arbiter #(.NCELL(8), .IDXW(3)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .cmd_a(cmd_a), .idx_a(idx_a),
    .req_b(req_b), .cmd_b(cmd_b), .idx_b(idx_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .q(q), .busy(busy), .err(err)
  );

  sr_bank_arbiter #(.NCELL(6), .IDXW(3)) dut6 (
    .clk(clk), .rst(rst),
    .req_a(req6), .cmd_a(cmd6), .idx_a(idx6),
    .req_b(req6_b), .cmd_b(cmd6_b), .idx_b(idx6_b),
    .gnt_a(gnt6_a), .gnt_b(gnt6_b), .q(q6), .busy(busy6), .err(err6)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: age counts edges since a command was accepted
  // (0 = grant cycle, 1 = gap cycle, otherwise ready to accept).
  logic [7:0] m_q = '0;
  logic       m_err = 1'b0;
  logic       m_last_b = 1'b1;
  logic       m_ga = 1'b0, m_gb = 1'b0;
  int         age = -1;
  logic [1:0] m_cmd;
  int         m_idx;

  always @(posedge clk) begin
    if (rst) begin
      m_q = '0; m_err = 1'b0; m_last_b = 1'b1; age = -1; m_ga = 1'b0; m_gb = 1'b0;
    end else begin
      m_ga = 1'b0; m_gb = 1'b0;
      if (age == 0) begin
        if (m_idx >= 8) m_err = 1'b1;
        else if (m_cmd == 2'b01) m_q[m_idx] = 1'b0;
        else if (m_cmd == 2'b10) m_q[m_idx] = 1'b1;
        else if (m_cmd == 2'b11) begin
`ifdef SR_TOGGLE_EN
          m_q[m_idx] = ~m_q[m_idx];
`else
          m_err = 1'b1;
`endif
        end
        age = 1;
      end else if (age == 1) begin
        age = 2;
      end else if (req_a || req_b) begin
        logic win_b;
        win_b    = req_b && (!req_a || !m_last_b);
        m_last_b = win_b;
        m_cmd    = win_b ? cmd_b : cmd_a;
        m_idx    = win_b ? int'(idx_b) : int'(idx_a);
        m_ga     = !win_b;
        m_gb     = win_b;
        age      = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model q", q, m_q);
      check("model err", err, m_err);
      check("model busy", busy, (age == 0 || age == 1));
      check("model gnt_a", gnt_a, m_ga & ~rst);
      check("model gnt_b", gnt_b, m_gb & ~rst);
      check("gnt exclusive", gnt_a & gnt_b, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_a(input logic [1:0] c, input logic [2:0] i, input string nm);
    req_a = 1'b1; cmd_a = c; idx_a = i;
    tick();
    @(negedge clk);
    check({nm, " gnt_a"}, gnt_a, 1);
    check({nm, " busy apply"}, busy, 1);
    tick();
    req_a = 1'b0;
    @(negedge clk);
    check({nm, " busy gap"}, busy, 1);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    req_a = 0; cmd_a = 0; idx_a = 0;
    req_b = 0; cmd_b = 0; idx_b = 0;
    req6 = 0; cmd6 = 0; idx6 = 0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset q", q, 8'h00);
    check("reset busy", busy, 0);
    check("reset err", err, 0);
    check("reset gnt", {gnt_a, gnt_b}, 2'b00);

    // Out-of-range index on the six-cell bank.
    req6 = 1'b1; cmd6 = 2'b10; idx6 = 3'd7;
    tick();
    @(negedge clk);
    check("n6 gnt", gnt6_a, 1);
    tick();
    req6 = 1'b0;
    tick();
    @(negedge clk);
    check("n6 q unchanged", q6, 6'h00);
    check("n6 err", err6, 1);
    req6 = 1'b1; cmd6 = 2'b10; idx6 = 3'd5;
    tick();
    tick();
    req6 = 1'b0;
    tick();
    @(negedge clk);
    check("n6 set idx5", q6, 6'h20);

    issue_a(2'b10, 3'd3, "set3");
    @(negedge clk);
    check("set3 q", q, 8'h08);
    check("set3 busy done", busy, 0);

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    req_a = 1'b1; cmd_a = 2'b10; idx_a = 3'd0;
    req_b = 1'b1; cmd_b = 2'b10; idx_b = 3'd7;
    tick();
    @(negedge clk);
    check("tie first gnt_a", gnt_a, 1);
    check("tie first gnt_b", gnt_b, 0);
    tick();
    req_a = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("tie second gnt_b", gnt_b, 1);
    check("tie second gnt_a", gnt_a, 0);
    tick();
    req_b = 1'b0;
    tick();
    @(negedge clk);
    check("tie final q", q, 8'h81);

    issue_a(2'b10, 3'd2, "set2");
    issue_a(2'b11, 3'd2, "both2");
    @(negedge clk);
`ifdef SR_TOGGLE_EN
    check("both2 q", q, 8'h81);
    check("both2 err", err, 0);
`else
    check("both2 q", q, 8'h85);
    check("both2 err", err, 1);
`endif

    req_a = 1'b1; cmd_a = 2'b10; idx_a = 3'd5;
    tick();
    rst = 1'b1;
    req_a = 1'b0;
    @(negedge clk);
    check("abort gnt_a", gnt_a, 0);
    check("abort busy", busy, 1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("abort q", q, 8'h00);
    check("abort idle", busy, 0);
    check("abort gnt", {gnt_a, gnt_b}, 2'b00);

    for (int n = 0; n < 3000; n++) begin
      logic sa, sb;
      @(negedge clk);
      sa = gnt_a;
      sb = gnt_b;
      tick();
      rst = ($urandom_range(0, 59) == 0);
      if (sa || !req_a) begin
        req_a = ($urandom_range(0, 2) != 0);
        cmd_a = 2'($urandom_range(0, 3));
        idx_a = 3'($urandom_range(0, 7));
      end
      if (sb || !req_b) begin
        req_b = ($urandom_range(0, 2) != 0);
        cmd_b = 2'($urandom_range(0, 3));
        idx_b = 3'($urandom_range(0, 7));
      end
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
